// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Brief    : Round-robin arbiter with per-grant beat limit driving a 4-way
//            one-hot mux select. Optional watchdog: MUX4_ARB_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
    parameter int MAX_BEATS = 16,
    parameter int CNT_WIDTH = 5,
    parameter int WD_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           i_req,
    input  logic                 i_beat,
    output logic [3:0]           o_sel,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_beat_cnt,
    output logic                 o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_LAST_BEAT = CNT_WIDTH'(MAX_BEATS - 1);

    state_t               r_state;
    logic [1:0]           r_ptr;
    logic [1:0]           r_winner;
    logic [3:0]           r_sel;
    logic                 r_busy;
    logic [CNT_WIDTH-1:0] r_beat_cnt;

    logic [1:0]           w_cand;
    logic [1:0]           w_win_idx;
    logic                 w_win_vld;
    logic                 w_norm_rel;
    logic                 w_wd_fire;
    logic                 w_release;

    // Scan from far to near so the source just after the pointer wins last.
    always_comb begin
        w_cand    = 2'd0;
        w_win_idx = 2'd0;
        w_win_vld = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            w_cand = r_ptr + 2'(k);
            if (i_req[w_cand]) begin
                w_win_idx = w_cand;
                w_win_vld = 1'b1;
            end
        end
    end

    assign w_norm_rel = !i_req[r_winner] || (i_beat && (r_beat_cnt == c_LAST_BEAT));
    assign w_release  = w_norm_rel || w_wd_fire;

`ifdef MUX4_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout;

    assign w_wd_fire = (r_state == S_GRANT) && !i_beat &&
                       (r_wd_cnt == WD_W'(WD_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_wd_fire && !w_norm_rel;
            if (r_state != S_GRANT || i_beat || w_wd_fire)
                r_wd_cnt <= '0;
            else
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_wd_fire = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= 2'd3;
            r_winner   <= 2'd0;
            r_sel      <= 4'd0;
            r_busy     <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_vld) begin
                        r_winner   <= w_win_idx;
                        r_sel      <= 4'b0001 << w_win_idx;
                        r_busy     <= 1'b1;
                        r_beat_cnt <= '0;
                        r_state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (i_beat)
                        r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
                    if (w_release) begin
                        r_sel   <= 4'd0;
                        r_busy  <= 1'b0;
                        r_ptr   <= r_winner;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_sel   <= 4'd0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_sel      = r_sel;
    assign o_busy     = r_busy;
    assign o_beat_cnt = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Brief    : Directed and randomized checks of mux4_rr_arbiter against a
//            cycle-level reference model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

    localparam int MAX_BEATS = 16;
    localparam int CNT_WIDTH = 5;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [3:0]           req = 4'd0;
    logic                 beat = 1'b0;
    logic [3:0]           sel;
    logic                 busy;
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic                 timeout;

    int n_chk  = 0;
    int n_fail = 0;

    mux4_rr_arbiter #(.MAX_BEATS(MAX_BEATS), .CNT_WIDTH(CNT_WIDTH), .WD_CYCLES(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (req),
        .i_beat     (beat),
        .o_sel      (sel),
        .o_busy     (busy),
        .o_beat_cnt (beat_cnt),
        .o_timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 owner holds the bus, 2 dead cycle.
    int m_mode, m_owner, m_ptr, m_cnt;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode  <= 0;
            m_owner <= 0;
            m_ptr   <= 3;
            m_cnt   <= 0;
        end else if (m_mode == 0) begin
            if (req != 4'd0) begin
                m_owner <= pick(req, m_ptr);
                m_cnt   <= 0;
                m_mode  <= 1;
            end
        end else if (m_mode == 1) begin
            m_cnt <= m_cnt + (beat ? 1 : 0);
            if (!req[m_owner] || (m_cnt + (beat ? 1 : 0) == MAX_BEATS)) begin
                m_ptr  <= m_owner;
                m_mode <= 2;
            end
        end else begin
            m_mode <= 0;
        end
    end

    always @(negedge clk) begin
        chk("sel",      int'(sel),      (m_mode == 1) ? (1 << m_owner) : 0);
        chk("busy",     int'(busy),     (m_mode == 1) ? 1 : 0);
        chk("beat_cnt", int'(beat_cnt), m_cnt);
        chk("timeout",  int'(timeout),  0);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Fair rotation with all sources requesting and continuous beats
        cyc(2);
        chk("reset_sel", int'(sel), 0);
        chk("reset_cnt", int'(beat_cnt), 0);
        req = 4'b1111;
        beat = 1'b1;
        rst = 1'b1;
        cyc(1);
        chk("rot_first_sel", int'(sel), 1);
        cyc(16);
        chk("rot_gap_sel", int'(sel), 0);
        chk("rot_gap_cnt", int'(beat_cnt), 16);
        cyc(1);
        chk("rot_idle_sel", int'(sel), 0);
        cyc(1);
        chk("rot_second_sel", int'(sel), 2);
        cyc(19);
        chk("rot_third_sel", int'(sel), 4);
        cyc(19);
        chk("rot_fourth_sel", int'(sel), 8);
        cyc(19);
        chk("rot_wrap_sel", int'(sel), 1);

        // Single source, three beats, then drop
        rst = 1'b0; req = 4'd0; beat = 1'b0;
        cyc(1);
        rst = 1'b1; req = 4'b0100;
        cyc(1);
        chk("drop_grant_sel", int'(sel), 4);
        beat = 1'b1;
        cyc(3);
        chk("drop_cnt3", int'(beat_cnt), 3);
        req = 4'd0; beat = 1'b0;
        cyc(1);
        chk("drop_sel", int'(sel), 0);
        chk("drop_busy", int'(busy), 0);
        chk("drop_cnt_hold", int'(beat_cnt), 3);

        // Lone requester hits the beat limit and is regranted after turnaround
        cyc(1);
        req = 4'b0010; beat = 1'b1;
        cyc(1);
        chk("limit_grant", int'(sel), 2);
        cyc(16);
        chk("limit_gap_sel", int'(sel), 0);
        chk("limit_gap_cnt", int'(beat_cnt), 16);
        cyc(2);
        chk("limit_regrant", int'(sel), 2);
        chk("limit_regrant_cnt", int'(beat_cnt), 0);

        // Asynchronous reset mid-grant of source 3
        req = 4'd0; beat = 1'b0;
        cyc(4);
        req = 4'b1000;
        cyc(1);
        chk("ar_grant3", int'(sel), 8);
        beat = 1'b1;
        cyc(2);
        #2 rst = 1'b0;
        #1;
        chk("ar_sel", int'(sel), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_cnt", int'(beat_cnt), 0);
        cyc(1);
        req = 4'b1001; beat = 1'b0; rst = 1'b1;
        cyc(1);
        chk("ar_ptr_reset", int'(sel), 1);

        // No beats for a long time: default build never times out
        cyc(70);
        chk("nowd_sel", int'(sel), 1);
        chk("nowd_timeout", int'(timeout), 0);

        // Beats outside a grant are ignored; a drop-cycle beat is counted
        req = 4'd0;
        cyc(1);
        beat = 1'b1;
        cyc(3);
        chk("idle_beat_cnt", int'(beat_cnt), 0);
        beat = 1'b0; req = 4'b0001;
        cyc(1);
        beat = 1'b1; req = 4'd0;
        cyc(1);
        chk("dropbeat_cnt", int'(beat_cnt), 1);
        chk("dropbeat_sel", int'(sel), 0);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom);
            beat = ($urandom_range(3) != 0);
            if ($urandom_range(499) == 0) begin
                #3 rst = 1'b0;
                cyc(1);
                rst = 1'b1;
            end else begin
                cyc(1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
